jtag_master: RTL and testbench

- Emulation-side JTAG initiator that drives TCK/TMS/TDI and samples TDO.
- Sits on the FPGA board and stimulates the MCU's JTAG pins (pad ring IO[4:0]) for debug and bring-up without an external probe.
- Accepts shift commands on a valid/ready interface and returns the captured TDO bits on a second valid/ready interface.

---
 rtl/jtag_master.sv | 156 +++++++++++++++
 tb/tb_jtag_master.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/jtag_master.sv
// jtag_master: valid/ready driven JTAG initiator that shifts TMS/TDI out and captures TDO.
// Optional TRST pulse command enabled by defining JTAG_MASTER_TRST_EN.
module jtag_master #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [LEN_W-1:0]   cmd_len_i,
    input  logic [MAX_LEN-1:0] cmd_tms_i,
    input  logic [MAX_LEN-1:0] cmd_tdi_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [MAX_LEN-1:0] rsp_tdo_o,
    output logic               busy_o,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
`ifdef JTAG_MASTER_TRST_EN
    input  logic               cmd_trst_i,
    output logic               trst_no,
`endif
    input  logic               tdo_i
);
`ifdef JTAG_MASTER_TRST_EN
    typedef enum logic [2:0] {IDLE, LOW, HIGH, RESP, TRST} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_t;
`endif
    // Divider is sized for the longest timed phase (the optional TRST pulse).
    localparam int DIV_W = $clog2(4 * CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
`ifdef JTAG_MASTER_TRST_EN
    localparam logic [DIV_W-1:0] TRST_LAST = DIV_W'(4 * CLK_DIV - 1);
`endif

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [LEN_W-1:0]   idx;
    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0] tms_sr;
    logic [MAX_LEN-1:0] tdi_sr;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   len_sat;
    logic [MAX_LEN-1:0] tms_nx;
    logic [MAX_LEN-1:0] tdi_nx;
    logic               div_end;
    logic               more;

    always_comb begin
        len_sat = cmd_len_i > LEN_MAX ? LEN_MAX : cmd_len_i;
        tms_nx  = tms_sr >> 1;
        tdi_nx  = tdi_sr >> 1;
        div_end = div_cnt == DIV_LAST;
        more    = idx + LEN_W'(1) < len_q;
    end

    assign cmd_ready_o = state == IDLE;
    assign busy_o      = state != IDLE;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            div_cnt     <= '0;
            idx         <= '0;
            len_q       <= '0;
            tms_sr      <= '0;
            tdi_sr      <= '0;
            mask        <= '0;
            tck_o       <= 1'b0;
            tms_o       <= 1'b0;
            tdi_o       <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_tdo_o   <= '0;
`ifdef JTAG_MASTER_TRST_EN
            trst_no     <= 1'b0;
`endif
        end else begin
`ifdef JTAG_MASTER_TRST_EN
            trst_no <= 1'b1;
`endif
            case (state)
                IDLE: if (cmd_valid_i) begin
                    rsp_tdo_o <= '0;
                    div_cnt   <= '0;
                    idx       <= '0;
                    mask      <= MAX_LEN'(1);
`ifdef JTAG_MASTER_TRST_EN
                    if (cmd_trst_i) begin
                        trst_no <= 1'b0;
                        state   <= TRST;
                    end else
`endif
                    if (len_sat == '0) begin
                        state <= RESP;
                    end else begin
                        len_q  <= len_sat;
                        tms_sr <= cmd_tms_i;
                        tdi_sr <= cmd_tdi_i;
                        tms_o  <= cmd_tms_i[0];
                        tdi_o  <= cmd_tdi_i[0];
                        state  <= LOW;
                    end
                end
                LOW: if (div_end) begin
                    div_cnt   <= '0;
                    tck_o     <= 1'b1;
                    rsp_tdo_o <= rsp_tdo_o | (mask & {MAX_LEN{tdo_i}});
                    state     <= HIGH;
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
                // TMS/TDI advance on the falling TCK edge so they are settled before the next rise.
                HIGH: if (div_end) begin
                    div_cnt <= '0;
                    tck_o   <= 1'b0;
                    idx     <= idx + LEN_W'(1);
                    mask    <= mask << 1;
                    tms_sr  <= tms_nx;
                    tdi_sr  <= tdi_nx;
                    if (more) begin
                        tms_o <= tms_nx[0];
                        tdi_o <= tdi_nx[0];
                        state <= LOW;
                    end else begin
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
                // Zero-length commands arrive with valid low and raise it one cycle later.
                RESP: if (!rsp_valid_o) begin
                    rsp_valid_o <= 1'b1;
                end else if (rsp_ready_i) begin
                    rsp_valid_o <= 1'b0;
                    state       <= IDLE;
                end
`ifdef JTAG_MASTER_TRST_EN
                TRST: if (div_cnt == TRST_LAST) begin
                    rsp_valid_o <= 1'b1;
                    state       <= RESP;
                end else begin
                    trst_no <= 1'b0;
                    div_cnt <= div_cnt + DIV_W'(1);
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: directed and random JTAG shift commands checked against a bit-level model.
module tb_jtag_master;
    localparam int CLK_DIV = 2;
    localparam int MAX_LEN = 32;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_tms = '0;
    logic [MAX_LEN-1:0] cmd_tdi = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [MAX_LEN-1:0] rsp_tdo;
    logic               busy, tck, tms, tdi, tdo;
`ifdef JTAG_MASTER_TRST_EN
    logic               cmd_trst = 1'b0;
    logic               trst_n;
`endif

    int total = 0, bad = 0;
    int cyc = 0, rise_total = 0, base = 0, last_rise = 0, prev_rise = 0;
    int n, lowc;
    bit stale, loop = 1'b0;
    logic [31:0] tdo_pat = '0;
    logic mon_tms [0:63];
    logic mon_tdi [0:63];

    jtag_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_len_i(cmd_len),
        .cmd_tms_i(cmd_tms), .cmd_tdi_i(cmd_tdi),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_tdo_o(rsp_tdo),
        .busy_o(busy), .tck_o(tck), .tms_o(tms), .tdi_o(tdi),
`ifdef JTAG_MASTER_TRST_EN
        .cmd_trst_i(cmd_trst), .trst_no(trst_n),
`endif
        .tdo_i(tdo)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cyc++;

    // Target model: TDO is either looped back from TDI or taken from a per-command pattern by bit index.
    assign tdo = loop ? tdi : tdo_pat[(rise_total - base) & 31];

    always @(posedge tck) begin
        mon_tms[rise_total % 64] = tms;
        mon_tdi[rise_total % 64] = tdi;
        prev_rise = last_rise;
        last_rise = cyc;
        rise_total++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input string tag, input logic [LEN_W-1:0] len, input logic [31:0] t_ms,
                           input logic [31:0] t_di, input logic [31:0] pat, input bit lb, input int hold);
        int eff, lat, k;
        bit ok;
        logic [31:0] m, exp_tdo, got_tms, got_tdi;
        eff = len > 32 ? 32 : int'(len);
        m = eff == 32 ? 32'hFFFF_FFFF : (32'h1 << eff) - 32'h1;
        exp_tdo = (lb ? t_di : pat) & m;
        lat = eff == 0 ? 1 : 2 * CLK_DIV * eff;
        check({tag, " ready_before"}, cmd_ready, 1);
        loop = lb;
        tdo_pat = pat;
        base = rise_total;
        cmd_valid = 1'b1;
        cmd_len = len;
        cmd_tms = t_ms;
        cmd_tdi = t_di;
        tick;
        cmd_valid = 1'b0;
        check({tag, " busy"}, {busy, cmd_ready}, 2'b10);
        k = 0;
        while (!rsp_valid && k < 2000) begin
            tick;
            k++;
        end
        check({tag, " latency"}, k, lat);
        check({tag, " rises"}, rise_total - base, eff);
        got_tms = '0;
        got_tdi = '0;
        for (int i = 0; i < eff; i++) begin
            got_tms[i] = mon_tms[(base + i) % 64];
            got_tdi[i] = mon_tdi[(base + i) % 64];
        end
        check({tag, " tms_bits"}, got_tms, t_ms & m);
        check({tag, " tdi_bits"}, got_tdi, t_di & m);
        check({tag, " rsp_tdo"}, rsp_tdo, exp_tdo);
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick;
            ok &= rsp_valid && rsp_tdo == exp_tdo && !cmd_ready && !tck;
        end
        if (hold > 0) check({tag, " hold_stable"}, ok, 1);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check({tag, " after_hs"}, {rsp_valid, cmd_ready, tck}, 3'b010);
    endtask

    initial begin
        tick;
        check("reset_state", {cmd_ready, busy, tck, tms, tdi, rsp_valid}, 6'b100000);
        check("reset_tdo", rsp_tdo, 0);
`ifdef JTAG_MASTER_TRST_EN
        check("reset_trst", trst_n, 0);
`endif
        rst_n = 1'b1;
        tick;
`ifdef JTAG_MASTER_TRST_EN
        check("trst_release", trst_n, 1);
`endif
        run_cmd("t1", 5, 32'h1F, 32'h0, 32'hFFFF_FFFF, 1'b0, 0);
        check("t1 tck_period", last_rise - prev_rise, 2 * CLK_DIV);
        check("t1 tms_held", tms, 1);
        run_cmd("t2", 32, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b1, 0);
        check("t2 tms_low", tms, 0);
        run_cmd("t3", 8, 32'h0, 32'hA5, 32'h0, 1'b1, 10);
        run_cmd("t3_next", 3, 32'h5, 32'h2, 32'h6, 1'b0, 0);
        run_cmd("t4_len0", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_cmd("t4_len40", 40, $urandom, $urandom, $urandom, 1'b0, 1);
        run_cmd("t4_len1", 1, 32'h1, 32'h1, 32'h1, 1'b0, 0);
        for (int r = 0; r < 12; r++)
            run_cmd($sformatf("rnd%0d", r), LEN_W'($urandom_range(1, 32)), $urandom, $urandom,
                    $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        // Reset while bit 3 is in its high phase.
        loop = 1'b1;
        base = rise_total;
        cmd_valid = 1'b1;
        cmd_len = 8;
        cmd_tdi = 32'hFF;
        tick;
        cmd_valid = 1'b0;
        n = 0;
        while (rise_total - base < 4 && n < 200) begin
            tick;
            n++;
        end
        check("t5 reached_bit3", rise_total - base, 4);
        rst_n = 1'b0;
        #1;
        check("t5 async_reset", {tck, rsp_valid, busy, cmd_ready}, 4'b0001);
        tick;
        tick;
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick;
            stale |= rsp_valid | tck;
        end
        check("t5 no_stale", stale, 0);
        run_cmd("t5_next", 6, 32'h2A, 32'h15, 32'h33, 1'b0, 2);
`ifdef JTAG_MASTER_TRST_EN
        base = rise_total;
        cmd_trst = 1'b1;
        cmd_valid = 1'b1;
        cmd_len = 5;
        tick;
        cmd_valid = 1'b0;
        cmd_trst = 1'b0;
        n = 0;
        lowc = 0;
        while (!rsp_valid && n < 200) begin
            if (!trst_n) lowc++;
            tick;
            n++;
        end
        check("t6 trst_low", lowc, 4 * CLK_DIV);
        check("t6 latency", n, 4 * CLK_DIV);
        check("t6 trst_back", trst_n, 1);
        check("t6 no_tck", rise_total - base, 0);
        check("t6 rsp_tdo", rsp_tdo, 0);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("t6 after_hs", {rsp_valid, cmd_ready}, 2'b01);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
